// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: rotating column drive, 2-flop row synchronizer,
// press/release debounce, one key code per accepted press.
module keypad_scanner #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DEBOUNCE      = 4
) (
    input  logic       keypad_clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic [1:0] dbg_state_o
);

    localparam int DW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE_S = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    sync1_q, row_s_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] match_q, match_d;
    logic [CW-1:0] rel_q, rel_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          down_q, down_d;

    logic          sample;
    logic          cand_low;
    logic          advance;
    logic [1:0]    lowest_row;

    always_ff @(posedge keypad_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            row_s_q <= 4'hF;
        end else begin
            sync1_q <= row_in;
            row_s_q <= sync1_q;
        end
    end

    always_ff @(posedge keypad_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            dwell_q <= '0;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            match_q <= '0;
            rel_q   <= '0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            col_q   <= col_d;
            row_q   <= row_d;
            match_q <= match_d;
            rel_q   <= rel_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            down_q  <= down_d;
        end
    end

    assign sample   = (dwell_q == DWELL_LAST);
    assign cand_low = ~row_s_q[row_q];

    always_comb begin
        lowest_row = 2'd0;
        if (!row_s_q[0])      lowest_row = 2'd0;
        else if (!row_s_q[1]) lowest_row = 2'd1;
        else if (!row_s_q[2]) lowest_row = 2'd2;
        else                  lowest_row = 2'd3;
    end

    // The dwell counter keeps running while the column is frozen so sample points
    // stay SETTLE_CYCLES apart; it restarts only when the column moves.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        dwell_d = sample ? '0 : dwell_q + 1'b1;
        row_d   = row_q;
        match_d = match_q;
        rel_d   = rel_q;
        code_d  = code_q;
        valid_d = 1'b0;
        down_d  = down_q;
        advance = 1'b0;

        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (row_s_q == 4'hF) begin
                        advance = 1'b1;
                    end else begin
                        row_d   = lowest_row;
                        match_d = CW'(1);
                        state_d = DEBOUNCE_S;
                    end
                end
            end
            DEBOUNCE_S: begin
                if (match_q == CNT_DONE) begin
                    code_d  = {col_q, row_q};
                    valid_d = 1'b1;
                    down_d  = 1'b1;
                    match_d = '0;
                    state_d = HELD;
                end else if (sample) begin
                    if (cand_low) begin
                        match_d = match_q + 1'b1;
                    end else begin
                        match_d = '0;
                        advance = 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            HELD: begin
                if (sample && !cand_low) begin
                    rel_d   = CW'(1);
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (rel_q == CNT_DONE) begin
                    down_d  = 1'b0;
                    rel_d   = '0;
                    advance = 1'b1;
                    state_d = SCAN;
                end else if (sample) begin
                    if (!cand_low) begin
                        rel_d = rel_q + 1'b1;
                    end else begin
                        rel_d   = '0;
                        state_d = HELD;
                    end
                end
            end
            default: state_d = SCAN;
        endcase

        if (advance) begin
            col_d   = col_q + 2'd1;
            dwell_d = '0;
        end
    end

    // key_valid is a single-cycle strobe with no backpressure; key_code is valid
    // on that cycle and holds until the next accepted press.
    assign col_sel     = ~(4'b0001 << col_q);
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_down    = down_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a virtual keypad drives row_in from col_sel; a scoreboard
// queue holds the key codes expected on each key_valid strobe.
module tb_keypad_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_in;
    logic [3:0] col_sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic [1:0] dbg_state;

    logic [3:0] pressed [4];
    logic [3:0] exp_q [$];
    int         checks;
    int         errors;
    int         n;
    int         valid_cnt;
    int         push_cnt;
    logic       prev_valid;

    typedef struct {
        int         col;
        logic [3:0] mask;
        logic [3:0] exp_code;
    } vec_t;
    vec_t tbl [6];

    keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE(4)) dut (
        .keypad_clk (clk),
        .rst_n      (rst_n),
        .row_in     (row_in),
        .col_sel    (col_sel),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_down   (key_down),
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col_sel[c]) row_in = row_in & ~pressed[c];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        n++;
    endtask

    task automatic tick_to(input int target);
        while (n < target) tick();
    endtask

    task automatic wait_col(input logic [3:0] cs);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && col_sel == cs; i++) tick();
        for (int i = 0; i < 100; i++) begin
            if (col_sel == cs) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("wait_col_timeout", ok, 1);
        n = 0;
    endtask

    task automatic push_exp(input logic [3:0] code);
        exp_q.push_back(code);
        push_cnt++;
    endtask

    task automatic wait_valid(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (key_valid) begin
                found = 1'b1;
                break;
            end
        end
        check(name, found, 1);
    endtask

    task automatic wait_release(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!key_down) begin
                found = 1'b1;
                break;
            end
        end
        check(name, found, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_key_valid: got code %0d expected no strobe (t=%0t)",
                         key_code, $time);
            end else begin
                check("key_code_on_valid", key_code, exp_q.pop_front());
            end
            if (prev_valid) check("valid_one_cycle", prev_valid, 0);
        end
        prev_valid = key_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] e;
        logic [3:0] mask;
        int         c;
        int         low;

        checks = 0; errors = 0; n = 0; valid_cnt = 0; push_cnt = 0; prev_valid = 1'b0;
        for (int i = 0; i < 4; i++) pressed[i] = 4'h0;
        tbl[0] = '{0, 4'b0001, 4'd0};
        tbl[1] = '{3, 4'b1000, 4'd15};
        tbl[2] = '{2, 4'b0010, 4'd9};
        tbl[3] = '{1, 4'b1001, 4'd4};
        tbl[4] = '{3, 4'b0110, 4'd13};
        tbl[5] = '{0, 4'b1100, 4'd2};

        // reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col_sel", col_sel, 4'b1110);
        check("rst_key_code", key_code, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_down", key_down, 0);

        // free-run column rotation, 4 cycles per column
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            e = 4'hF;
            e[(k / 4) % 4] = 1'b0;
            check("free_run_col_sel", col_sel, e);
            @(negedge clk);
        end

        // clean press of key 9, latency, glitch during hold, release latency
        pressed[2] = 4'b0010;
        push_exp(4'd9);
        wait_col(4'b1011);
        begin
            int lat;
            lat = -1;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (key_valid) begin
                    lat = n;
                    break;
                end
            end
            check("press_latency", lat, 17);
        end
        check("press_key_code", key_code, 9);
        check("press_key_down", key_down, 1);
        check("press_col_frozen", col_sel, 4'b1011);
        tick();
        check("press_valid_drops", key_valid, 0);
        tick_to(21);
        pressed[2] = 4'h0;
        tick_to(24);
        pressed[2] = 4'b0010;
        tick_to(29);
        check("glitch_key_down", key_down, 1);
        tick_to(36);
        check("glitch_key_down_late", key_down, 1);
        check("glitch_col_frozen", col_sel, 4'b1011);
        tick_to(37);
        pressed[2] = 4'h0;
        tick_to(52);
        check("release_before_latency", key_down, 1);
        tick_to(53);
        check("release_latency", key_down, 0);
        check("release_col_advance", col_sel, 4'b0111);
        check("release_code_holds", key_code, 9);
        repeat (10) tick();

        // bounce: two low samples then high
        pressed[2] = 4'b0010;
        wait_col(4'b1011);
        tick_to(8);
        pressed[2] = 4'h0;
        tick_to(11);
        check("bounce_col_frozen", col_sel, 4'b1011);
        tick_to(12);
        check("bounce_resume_col", col_sel, 4'b0111);
        check("bounce_key_down", key_down, 0);
        repeat (20) tick();

        // multi-key: rows 0 and 3 in column 1, then a column-3 key while held
        pressed[1] = 4'b1001;
        push_exp(4'd4);
        wait_valid("multi_valid_timeout");
        check("multi_key_code", key_code, 4);
        pressed[3] = 4'b0100;
        repeat (40) tick();
        check("multi_col_frozen", col_sel, 4'b1101);
        check("multi_key_down", key_down, 1);
        pressed[1] = 4'h0;
        pressed[3] = 4'h0;
        wait_release("multi_release_timeout");
        repeat (20) tick();

        // asynchronous reset while HELD
        pressed[2] = 4'b0010;
        push_exp(4'd9);
        wait_valid("rstmid_valid_timeout");
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_key_code", key_code, 0);
        check("rstmid_key_down", key_down, 0);
        check("rstmid_col_sel", col_sel, 4'b1110);
        repeat (2) tick();
        rst_n = 1'b1;
        push_exp(4'd9);
        wait_valid("rstmid_fresh_valid_timeout");
        check("rstmid_fresh_code", key_code, 9);
        repeat (30) tick();
        pressed[2] = 4'h0;
        wait_release("rstmid_release_timeout");
        repeat (20) tick();

        // table of single-column presses
        for (int i = 0; i < 6; i++) begin
            pressed[tbl[i].col] = tbl[i].mask;
            push_exp(tbl[i].exp_code);
            wait_valid("tbl_valid_timeout");
            check("tbl_key_code", key_code, tbl[i].exp_code);
            check("tbl_key_down", key_down, 1);
            pressed[tbl[i].col] = 4'h0;
            wait_release("tbl_release_timeout");
            repeat (10) tick();
        end

        // random presses, some preceded by a short glitch that must be rejected
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                c = $urandom_range(0, 3);
                pressed[c] = 4'($urandom_range(1, 15));
                repeat ($urandom_range(1, 5)) tick();
                pressed[c] = 4'h0;
                repeat (20) tick();
            end
            c = $urandom_range(0, 3);
            mask = 4'($urandom_range(1, 15));
            low = 0;
            for (int r = 3; r >= 0; r--) if (mask[r]) low = r;
            pressed[c] = mask;
            push_exp(4'(c * 4 + low));
            wait_valid("rand_valid_timeout");
            repeat ($urandom_range(0, 30)) tick();
            check("rand_key_down", key_down, 1);
            pressed[c] = 4'h0;
            wait_release("rand_release_timeout");
            repeat ($urandom_range(0, 10)) tick();
        end

        repeat (40) tick();
        check("exp_q_empty", exp_q.size(), 0);
        check("valid_count", valid_cnt, push_cnt);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
